// File: rtl/umi_regmaster.sv
// UMI register master: turns single local register read/write requests into UMI
// request packets and returns the matching response data and status.
module umi_regmaster #(
    parameter int unsigned    AW       = 64,
    parameter int unsigned    CW       = 32,
    parameter int unsigned    DW       = 256,
    parameter int unsigned    RW       = 64,
    parameter logic [AW-1:0]  HOSTADDR = '0,
    parameter int unsigned    TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          reg_req,
    input  logic          reg_write,
    input  logic          reg_posted,
    input  logic [AW-1:0] reg_addr,
    input  logic [2:0]    reg_size,
    input  logic [RW-1:0] reg_wrdata,
    output logic          reg_ready,
    output logic          reg_done,
    output logic [1:0]    reg_err,
    output logic [RW-1:0] reg_rddata,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam int unsigned CNTW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t            state;
    logic              is_write;
    logic              is_posted;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_inc;
    logic [CW-1:0]     req_cmd;
    logic [4:0]        resp_op;
    logic [1:0]        resp_err;
    logic [4:0]        exp_op;
    logic              unused_ok;

    // Command layout: opcode [4:0], size [7:5], len [15:8], eom [22], err [26:25].
    always_comb begin
        req_cmd       = '0;
        req_cmd[4:0]  = !reg_write ? UMI_REQ_READ :
                        reg_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE;
        req_cmd[7:5]  = reg_size;
        req_cmd[22]   = 1'b1;
        resp_op       = uhost_resp_cmd[4:0];
        resp_err      = uhost_resp_cmd[26:25];
        exp_op        = is_write ? UMI_RESP_WRITE : UMI_RESP_READ;
        cnt_inc       = (cnt == CNTW'(TIMEOUT)) ? cnt : cnt + 1'b1;
    end

    assign reg_ready         = (state == StIdle);
    assign uhost_resp_ready  = (state != StReq);
    assign uhost_req_srcaddr = HOSTADDR;
    assign unused_ok = ^{uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data, uhost_resp_cmd};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state             <= StIdle;
            is_write          <= 1'b0;
            is_posted         <= 1'b0;
            cnt               <= '0;
            reg_done          <= 1'b0;
            reg_err           <= 2'b00;
            reg_rddata        <= '0;
            uhost_req_valid   <= 1'b0;
            uhost_req_cmd     <= '0;
            uhost_req_dstaddr <= '0;
            uhost_req_data    <= '0;
        end else begin
            reg_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Responses arriving here are stray or late and are dropped.
                    if (reg_req) begin
                        is_write          <= reg_write;
                        is_posted         <= reg_write & reg_posted;
                        uhost_req_cmd     <= req_cmd;
                        uhost_req_dstaddr <= reg_addr;
                        uhost_req_data    <= DW'(reg_wrdata);
                        uhost_req_valid   <= 1'b1;
                        state             <= StReq;
                    end
                end
                StReq: begin
                    if (uhost_req_ready) begin
                        uhost_req_valid <= 1'b0;
                        cnt             <= '0;
                        if (is_posted) begin
                            reg_done <= 1'b1;
                            reg_err  <= 2'b00;
                            state    <= StIdle;
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (uhost_resp_valid) begin
                        reg_done <= 1'b1;
                        state    <= StIdle;
                        if (resp_op != exp_op) begin
                            reg_err <= 2'b10;
                        end else begin
                            reg_err <= (resp_err != 2'b00) ? 2'b01 : 2'b00;
                            if (!is_write) begin
                                reg_rddata <= uhost_resp_data[RW-1:0];
                            end
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNTW'(TIMEOUT)) begin
                            reg_done <= 1'b1;
                            reg_err  <= 2'b11;
                            state    <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
